// File: rtl/light_bar_arbiter_if.sv
// Pattern-source request/pattern bus and registered light-bar drive for light_bar_arbiter.
// Sources drive req/srcGreen/srcRed; the arbiter drives grant/lights/busy.
interface light_bar_arbiter_if;
    logic [3:0]  req;
    logic [31:0] srcGreen;
    logic [31:0] srcRed;
    logic [3:0]  grant;
    logic [0:7]  greenLight;
    logic [0:7]  redLight;
    logic        busy;

    modport master (
        output req,
        output srcGreen,
        output srcRed,
        input  grant,
        input  greenLight,
        input  redLight,
        input  busy
    );

    modport slave (
        input  req,
        input  srcGreen,
        input  srcRed,
        output grant,
        output greenLight,
        output redLight,
        output busy
    );
endinterface

// File: rtl/light_bar_arbiter.sv
// Round-robin owner arbiter for a 4-source red/green light bar with a minimum dwell; LIGHTBAR_BLANK_EN adds a blank gap between owners.
// Latency: grant one edge after the deciding cycle; lights follow the registered grant one edge later.
// Backpressure: none; an owner keeps the bar until it drops req or its dwell expires while others wait.
module light_bar_arbiter #(
    parameter int unsigned TICK_DIV    = 12500000,
    parameter int unsigned DWELL_TICKS = 4
) (
    input  logic               clock,
    input  logic               reset,
    light_bar_arbiter_if.slave bus
);

    localparam logic [30:0] PRESC_LAST = 31'(TICK_DIV - 1);
    localparam logic [7:0]  DWELL_MAX  = 8'(DWELL_TICKS);

`ifdef LIGHTBAR_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [30:0] presc_q, presc_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [1:0]  last_q,  last_d;
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  green_q, green_d;
    logic [7:0]  red_q,   red_d;
    logic        busy_q,  busy_d;

    logic        tick;
    logic [3:0]  pick_all;
    logic [3:0]  pick_other;
    logic        owner_holds;
    logic        dwell_full;

    // First set bit searching upward from last+1; the last owner itself has lowest priority.
    function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [3:0] g;
        logic [1:0] idx;
        g = 4'b0000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                g = 4'b0001 << idx;
            end
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] slice_of(input logic [31:0] src, input logic [3:0] g);
        logic [7:0] s;
        case (g)
            4'b0001: s = src[7:0];
            4'b0010: s = src[15:8];
            4'b0100: s = src[23:16];
            4'b1000: s = src[31:24];
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign tick        = (presc_q == PRESC_LAST);
    assign pick_all    = rr_pick(bus.req, last_q);
    assign pick_other  = rr_pick(bus.req & ~grant_q, last_q);
    assign owner_holds = |(bus.req & grant_q);
    assign dwell_full  = (dwell_q == DWELL_MAX);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        dwell_d = dwell_q;
        last_d  = last_q;
        presc_d = tick ? 31'd0 : presc_q + 31'd1;

        case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (|bus.req) begin
                    state_d = ST_OWN;
                    grant_d = pick_all;
                    dwell_d = 8'd0;
                    last_d  = onehot_idx(pick_all);
                end
            end

            ST_OWN: begin
                if (!owner_holds && pick_other == 4'b0000) begin
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                    dwell_d = 8'd0;
                end else if (!owner_holds || (dwell_full && pick_other != 4'b0000)) begin
                    // Handover beats a coincident tick: new owner's dwell starts from zero.
                    dwell_d = 8'd0;
`ifdef LIGHTBAR_BLANK_EN
                    state_d = ST_BLANK;
                    grant_d = 4'b0000;
`else
                    grant_d = pick_other;
                    last_d  = onehot_idx(pick_other);
`endif
                end else if (tick && !dwell_full) begin
                    dwell_d = dwell_q + 8'd1;
                end
            end

`ifdef LIGHTBAR_BLANK_EN
            ST_BLANK: begin
                grant_d = 4'b0000;
                if (tick) begin
                    if (|bus.req) begin
                        state_d = ST_OWN;
                        grant_d = pick_all;
                        dwell_d = 8'd0;
                        last_d  = onehot_idx(pick_all);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                dwell_d = 8'd0;
            end
        endcase

        // Lights come from the registered grant but blank together with it.
        if (grant_d == 4'b0000) begin
            green_d = 8'h00;
            red_d   = 8'h00;
        end else begin
            green_d = slice_of(bus.srcGreen, grant_q);
            red_d   = slice_of(bus.srcRed,   grant_q);
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= 31'd0;
            dwell_q <= 8'd0;
            last_q  <= 2'd3;
            grant_q <= 4'b0000;
            green_q <= 8'h00;
            red_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            green_q <= green_d;
            red_q   <= red_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.greenLight = green_q;
    assign bus.redLight   = red_q;
    assign bus.busy       = busy_q;

endmodule
